// File: rtl/lsu_pkg.sv
// lsu_pkg: shared memory size, access-size encodings and FSM states for the load/store unit.
package lsu_pkg;
   localparam int unsigned MEM_SIZE = 4096;
   localparam logic [2:0] SZ_BYTE = 3'd1;
   localparam logic [2:0] SZ_HALF = 3'd2;
   localparam logic [2:0] SZ_WORD = 3'd4;
   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_e;
   function automatic logic size_ok(input logic [2:0] size);
      return size == SZ_BYTE || size == SZ_HALF || size == SZ_WORD;
   endfunction
endpackage

// File: rtl/lsu_check.sv
// lsu_check: flags accesses with a bad size, a misaligned address or a range past the end of memory.
module lsu_check
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_SIZE
) (
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   output logic        fault
);
   logic [32:0] end_addr;
   always_comb begin
      // 33-bit sum so an access wrapping past 0xFFFFFFFF is out of range
      end_addr = {1'b0, addr} + {30'd0, size};
      fault = !size_ok(size) ||
              (size == SZ_HALF && addr[0]) ||
              (size == SZ_WORD && addr[1:0] != 2'b00) ||
              end_addr > 33'(MEM_BYTES);
   end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the big-endian ram, one RAM cycle per request.
// Define LSU_ADDR_CHECK_EN to enable size/alignment/range exceptions.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_SIZE
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_size,
   input  logic        i_req_sign,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [4:0]  i_req_rd,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic [4:0]  o_rsp_rd,
   output logic        o_rsp_exc,
   output logic [31:0] o_rsp_badaddr,
   output logic [31:0] o_mem_addr,
   output logic [2:0]  o_mem_insize,
   output logic        o_mem_insign,
   output logic [2:0]  o_mem_outsize,
   output logic [31:0] o_mem_data,
   input  logic [31:0] i_mem_data
);
   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [4:0]  rsp_rd_q, rsp_rd_d;
   logic        rsp_exc_q, rsp_exc_d;
   logic [31:0] rsp_badaddr_q, rsp_badaddr_d;
   logic        accept, fault, access;
   logic [2:0]  ram_size;

`ifdef LSU_ADDR_CHECK_EN
   lsu_check #(.MEM_BYTES(MEM_BYTES)) u_check (
      .addr  (i_req_addr),
      .size  (i_req_size),
      .fault (fault)
   );
`else
   // the memory range only matters when checking is enabled
   assign fault = (MEM_BYTES == 0) && 1'b0;
`endif

   assign o_req_ready = state_q == LSU_IDLE || (state_q == LSU_RESP && i_rsp_ready);
   assign access      = state_q == LSU_ACCESS;
   assign ram_size    = (access && size_ok(size_q)) ? size_q : 3'd0;

   always_comb begin
      accept        = i_req_valid && o_req_ready;
      state_d       = state_q;
      we_d          = we_q;
      size_d        = size_q;
      sign_d        = sign_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rsp_data_d    = rsp_data_q;
      rsp_rd_d      = rsp_rd_q;
      rsp_exc_d     = rsp_exc_q;
      rsp_badaddr_d = rsp_badaddr_q;
      if (accept) begin
         we_d          = i_req_we;
         size_d        = i_req_size;
         sign_d        = i_req_sign;
         addr_d        = i_req_addr;
         wdata_d       = i_req_wdata;
         rsp_rd_d      = i_req_rd;
         rsp_data_d    = 32'd0;
         rsp_exc_d     = fault;
         rsp_badaddr_d = fault ? i_req_addr : 32'd0;
         state_d       = fault ? LSU_RESP : LSU_ACCESS;
      end else if (state_q == LSU_ACCESS) begin
         rsp_data_d = we_q ? 32'd0 : i_mem_data;
         state_d    = LSU_RESP;
      end else if (state_q == LSU_RESP && i_rsp_ready) begin
         state_d = LSU_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= LSU_IDLE;
         we_q          <= 1'b0;
         size_q        <= 3'd0;
         sign_q        <= 1'b0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         rsp_data_q    <= 32'd0;
         rsp_rd_q      <= 5'd0;
         rsp_exc_q     <= 1'b0;
         rsp_badaddr_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         size_q        <= size_d;
         sign_q        <= sign_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rsp_data_q    <= rsp_data_d;
         rsp_rd_q      <= rsp_rd_d;
         rsp_exc_q     <= rsp_exc_d;
         rsp_badaddr_q <= rsp_badaddr_d;
      end
   end

   // RAM strobes derive from the async-reset state, so reset kills a store cycle at once
   assign o_mem_addr    = addr_q;
   assign o_mem_data    = wdata_q;
   assign o_mem_insize  = we_q ? 3'd0 : ram_size;
   assign o_mem_outsize = we_q ? ram_size : 3'd0;
   assign o_mem_insign  = access && !we_q && sign_q;
   assign o_rsp_valid   = state_q == LSU_RESP;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_rd      = rsp_rd_q;
   assign o_rsp_exc     = rsp_exc_q;
   assign o_rsp_badaddr = rsp_badaddr_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vectors, multi-cycle corner sequences and random requests against a byte-level memory model.
module tb_lsu;
   localparam int MB = 256;
`ifdef LSU_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        i_clk = 1'b0, i_rst_n = 1'b0;
   logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_req_sign = 1'b0, i_rsp_ready = 1'b0;
   logic [2:0]  i_req_size = 3'd0;
   logic [31:0] i_req_addr = 32'd0, i_req_wdata = 32'd0;
   logic [4:0]  i_req_rd = 5'd0;
   logic        o_req_ready, o_rsp_valid, o_rsp_exc, o_mem_insign;
   logic [31:0] o_rsp_data, o_rsp_badaddr, o_mem_addr, o_mem_data, i_mem_data;
   logic [4:0]  o_rsp_rd;
   logic [2:0]  o_mem_insize, o_mem_outsize;

   lsu #(.MEM_BYTES(MB)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_size(i_req_size), .i_req_sign(i_req_sign), .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata), .i_req_rd(i_req_rd),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_rsp_rd(o_rsp_rd), .o_rsp_exc(o_rsp_exc), .o_rsp_badaddr(o_rsp_badaddr),
      .o_mem_addr(o_mem_addr), .o_mem_insize(o_mem_insize), .o_mem_insign(o_mem_insign),
      .o_mem_outsize(o_mem_outsize), .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
   );

   always #5 i_clk = ~i_clk;

   // big-endian byte RAM behind the unit; bytes past MB read 0 and ignore writes
   logic [7:0] ram [MB] = '{default: 8'h00};
   logic [7:0] rb [4];
   int         ram_writes = 0;
   always_comb begin
      for (int i = 0; i < 4; i++)
         rb[i] = ({1'b0, o_mem_addr} + 33'(i) < 33'(MB)) ? ram[o_mem_addr[7:0] + 8'(i)] : 8'h00;
      case (o_mem_insize)
         3'd1:    i_mem_data = {{24{o_mem_insign & rb[0][7]}}, rb[0]};
         3'd2:    i_mem_data = {{16{o_mem_insign & rb[0][7]}}, rb[0], rb[1]};
         3'd4:    i_mem_data = {rb[0], rb[1], rb[2], rb[3]};
         default: i_mem_data = 32'h0;
      endcase
   end
   always @(posedge i_clk)
      if (o_mem_outsize != 3'd0) begin
         ram_writes <= ram_writes + 1;
         for (int i = 0; i < 4; i++)
            if (i < int'(o_mem_outsize) && {1'b0, o_mem_addr} + 33'(i) < 33'(MB))
               ram[o_mem_addr[7:0] + 8'(i)] <= o_mem_data[8*(int'(o_mem_outsize)-1-i) +: 8];
      end

   typedef struct packed {
      logic        exc;
      logic [31:0] bad;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  sz;
      logic        sg;
      logic [31:0] addr, wdata;
      logic [4:0]  rd;
      rsp_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0, checks = 0;
   logic [7:0] ref_mem [MB] = '{default: 8'h00};

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // reference: what the unit plus memory must return for one request, updating the memory image
   function automatic rsp_t model(input logic we, input logic [2:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd);
      rsp_t            r = '0;
      int              n = int'(sz);
      bit              szok = (n == 1 || n == 2 || n == 4);
      longint unsigned ad;
      if (CHK && (!szok || a % n != 0 || {32'd0, a} + n > MB)) begin
         r.exc = 1'b1;
         r.bad = a;
         return r;
      end
      if (!szok) return r;
      for (int i = 0; i < n; i++) begin
         ad = {32'd0, a} + i;
         if (we) begin
            if (ad < MB) ref_mem[ad[7:0]] = wd[8*(n-1-i) +: 8];
         end else
            r.data = (r.data << 8) | ((ad < MB) ? 32'(ref_mem[ad[7:0]]) : 32'h0);
      end
      if (!we && sg && n < 4 && r.data[8*n-1]) r.data = r.data | (32'hFFFFFFFF << (8*n));
      return r;
   endfunction

   task automatic add(input string n, input logic we, input logic [2:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input logic exc, input logic [31:0] bad, input logic [31:0] data);
      vec_t v;
      v.name = n; v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd; v.rd = rd;
      v.exp.exc = exc; v.exp.bad = bad; v.exp.data = data;
      vecs.push_back(v);
   endtask

   // one request from IDLE, response held for 'hold' cycles before it is consumed
   task automatic do_req(input string n, input logic we, input logic [2:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input int hold, output rsp_t got, output logic [4:0] grd,
                         output int lat, output bit seen);
      @(negedge i_clk);
      chk({n, "_ready"}, 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_sign = sg;
      i_req_addr = a; i_req_wdata = wd; i_req_rd = rd;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      lat = 1;
      seen = 1'b0;
      while (!o_rsp_valid && lat < 8) begin
         seen |= (o_mem_insize != 3'd0 || o_mem_outsize != 3'd0);
         @(posedge i_clk); #1;
         lat++;
      end
      if (!o_rsp_valid) begin
         errors++;
         $display("FAIL %s_timeout: no response within %0d cycles", n, lat);
      end
      got = {o_rsp_exc, o_rsp_badaddr, o_rsp_data};
      grd = o_rsp_rd;
      for (int h = 0; h < hold; h++) begin
         @(posedge i_clk); #1;
         chk({n, "_hold"}, 32'({o_rsp_valid, o_req_ready, {o_rsp_exc, o_rsp_badaddr, o_rsp_data} == got}), 32'b101);
      end
      i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;
   endtask

   task automatic compare(input string n, input logic [2:0] sz, input logic [4:0] rd, input rsp_t exp,
                          input rsp_t got, input logic [4:0] grd, input int lat, input bit seen);
      chk({n, "_exc"}, 32'(got.exc), 32'(exp.exc));
      chk({n, "_badaddr"}, got.bad, exp.bad);
      chk({n, "_data"}, got.data, exp.data);
      chk({n, "_rd"}, 32'(grd), 32'(rd));
      chk({n, "_latency"}, 32'(lat), exp.exc ? 32'd1 : 32'd2);
      chk({n, "_ramcycle"}, 32'(seen), 32'(!exp.exc && (sz == 1 || sz == 2 || sz == 4)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rsp_t       got, exp;
      logic [4:0] grd;
      int         lat, w0;
      bit         seen;
      logic       we, sg;
      logic [2:0] sz;
      logic [31:0] a, wd;
      logic [4:0]  rd;

      add("st_w10",    1, 4, 0, 32'h10,       32'hDEADBEEF, 5'd3,  0, 0, 0);
      add("ld_w10",    0, 4, 0, 32'h10,       32'h0,        5'd4,  0, 0, 32'hDEADBEEF);
      add("st_b21",    1, 1, 0, 32'h21,       32'h80,       5'd5,  0, 0, 0);
      add("st_b20",    1, 1, 0, 32'h20,       32'hC3,       5'd6,  0, 0, 0);
      add("ld_bs21",   0, 1, 1, 32'h21,       32'h0,        5'd7,  0, 0, 32'hFFFFFF80);
      add("ld_bu21",   0, 1, 0, 32'h21,       32'h0,        5'd8,  0, 0, 32'h00000080);
      add("ld_hs20",   0, 2, 1, 32'h20,       32'h0,        5'd9,  0, 0, 32'hFFFFC380);
      add("ld_w12",    0, 4, 0, 32'h12,       32'h0,        5'd10, CHK, CHK ? 32'h12 : 0, CHK ? 0 : 32'hBEEF0000);
      add("ld_hu21",   0, 2, 0, 32'h21,       32'h0,        5'd11, CHK, CHK ? 32'h21 : 0, CHK ? 0 : 32'h00008000);
      add("st_wfe",    1, 4, 0, 32'hFE,       32'h11223344, 5'd12, CHK, CHK ? 32'hFE : 0, 0);
      add("ld_hufe",   0, 2, 0, 32'hFE,       32'h0,        5'd13, 0, 0, CHK ? 0 : 32'h1122);
      add("st_wwrap",  1, 4, 0, 32'hFFFFFFFE, 32'h55667788, 5'd14, CHK, CHK ? 32'hFFFFFFFE : 0, 0);
      add("ld_buff",   0, 1, 0, 32'hFF,       32'h0,        5'd15, 0, 0, CHK ? 0 : 32'h22);
      add("ld_sz3",    0, 3, 0, 32'h10,       32'h0,        5'd16, CHK, CHK ? 32'h10 : 0, 0);
      add("st_sz3",    1, 3, 0, 32'h10,       32'h0,        5'd17, CHK, CHK ? 32'h10 : 0, 0);
      add("ld_w10b",   0, 4, 0, 32'h10,       32'h0,        5'd18, 0, 0, 32'hDEADBEEF);
      add("ld_wfc",    0, 4, 0, 32'hFC,       32'h0,        5'd19, 0, 0, CHK ? 0 : 32'h00001122);
      add("ld_w100",   0, 4, 0, 32'h100,      32'h0,        5'd20, CHK, CHK ? 32'h100 : 0, 0);

      repeat (3) @(negedge i_clk);
      chk("rst_ready", 32'(o_req_ready), 32'd1);
      chk("rst_outputs", 32'(|{o_rsp_valid, o_rsp_data, o_rsp_rd, o_rsp_exc, o_rsp_badaddr,
                               o_mem_addr, o_mem_insize, o_mem_insign, o_mem_outsize, o_mem_data}), 32'd0);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_no_write", 32'(ram_writes), 32'd0);

      for (int k = 0; k < vecs.size(); k++) begin
         void'(model(vecs[k].we, vecs[k].sz, vecs[k].sg, vecs[k].addr, vecs[k].wdata));
         do_req(vecs[k].name, vecs[k].we, vecs[k].sz, vecs[k].sg, vecs[k].addr, vecs[k].wdata,
                vecs[k].rd, 0, got, grd, lat, seen);
         compare(vecs[k].name, vecs[k].sz, vecs[k].rd, vecs[k].exp, got, grd, lat, seen);
      end

      // backpressure: held load response, a store waiting, then handshake and accept on one edge
      void'(model(0, 4, 0, 32'h10, 0));
      void'(model(1, 2, 0, 32'h30, 32'hA5A5));
      @(negedge i_clk);
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 3'd4; i_req_sign = 1'b0;
      i_req_addr = 32'h10; i_req_rd = 5'd21;
      @(posedge i_clk); #1;
      i_req_we = 1'b1; i_req_size = 3'd2; i_req_addr = 32'h30; i_req_wdata = 32'hA5A5; i_req_rd = 5'd22;
      lat = 0;
      while (!o_rsp_valid && lat < 8) begin @(negedge i_clk); lat++; end
      for (int h = 0; h < 5; h++) begin
         @(negedge i_clk);
         chk("bp_valid", 32'(o_rsp_valid), 32'd1);
         chk("bp_ready", 32'(o_req_ready), 32'd0);
         chk("bp_data", o_rsp_data, 32'hDEADBEEF);
         chk("bp_rd", 32'(o_rsp_rd), 32'd21);
      end
      i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0; i_req_valid = 1'b0;
      chk("b2b_access", 32'({o_rsp_valid, o_mem_outsize}), 32'd2);
      @(posedge i_clk); #1;
      chk("b2b_rsp", 32'({o_rsp_valid, o_rsp_rd, o_rsp_data}), {1'b1, 5'd22, 32'd0} & 32'hFFFFFFFF);
      chk("b2b_rsp_valid_rd", 32'({o_rsp_valid, o_rsp_rd}), 32'({1'b1, 5'd22}));
      i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;

      // reset asserted in the middle of a store's RAM cycle
      @(negedge i_clk);
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 3'd4; i_req_addr = 32'h40;
      i_req_wdata = 32'hCAFEF00D; i_req_rd = 5'd23;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      chk("rst_mid_outsize_pre", 32'(o_mem_outsize), 32'd4);
      w0 = ram_writes;
      i_rst_n = 1'b0;
      #1;
      chk("rst_mid_outsize_async", 32'(o_mem_outsize), 32'd0);
      @(posedge i_clk); #1;
      chk("rst_mid_rsp_dropped", 32'(o_rsp_valid), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rst_mid_no_write", 32'(ram_writes - w0), 32'd0);
      exp = model(0, 4, 0, 32'h40, 0);
      do_req("rst_mid_ld", 0, 4, 0, 32'h40, 0, 5'd24, 0, got, grd, lat, seen);
      chk("rst_mid_ld_data", got.data, 32'h0);

      for (int k = 0; k < 80; k++) begin
         we = 1'($urandom);
         sg = 1'($urandom);
         rd = 5'($urandom);
         wd = $urandom;
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
         case ($urandom_range(0, 9))
            7:       a = MB - $urandom_range(0, 4);
            8:       a = 32'hFFFFFFFF - $urandom_range(0, 3);
            9:       a = $urandom;
            default: a = 32'h80 + $urandom_range(0, 127);
         endcase
         exp = model(we, sz, sg, a, wd);
         do_req("rnd", we, sz, sg, a, wd, rd, $urandom_range(0, 2), got, grd, lat, seen);
         compare("rnd", sz, rd, exp, got, grd, lat, seen);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the MIPS execute stage and the byte-addressed, big-endian `ram`. It accepts one memory request per handshake and latches it, then drives the RAM ports for exactly one cycle. It captures read data and returns a registered response to writeback. It also flags misaligned and out-of-range accesses so they never reach the memory array.

## Interface
Parameters:
- `MEM_BYTES`, default `` `MEM_SIZE ``: number of addressable bytes behind the RAM.

Ports:
- `i_clk`  in  1  the single clock; rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  request accepted this cycle when high together with `i_req_valid`.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_size`  in  3  access size in bytes: 1, 2 or 4.
- `i_req_sign`  in  1  sign-extend loads.
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-aligned.
- `i_req_rd`  in  5  destination register tag, echoed in the response.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  response consumed.
- `o_rsp_data`  out  32  load result; 0 for stores and exceptions.
- `o_rsp_rd`  out  5  echoed tag.
- `o_rsp_exc`  out  1  address exception.
- `o_rsp_badaddr`  out  32  faulting address; 0 when `o_rsp_exc`=0.
- `o_mem_addr`  out  32  to RAM `i_addr`.
- `o_mem_insize`  out  3  to RAM read size.
- `o_mem_insign`  out  1  to RAM sign control.
- `o_mem_outsize`  out  3  to RAM write size.
- `o_mem_data`  out  32  to RAM write data.
- `i_mem_data`  in  32  from RAM read data.

## Operation
The FSM has three states: IDLE, ACCESS and RESP.

- **Ready:** `o_req_ready` = (state==IDLE) | (state==RESP & `i_rsp_ready`).
- **Accept:** on an accept edge, latch we, size, sign, addr, wdata and rd.
  - If the check passes, go to ACCESS.
  - If it fails, go to RESP with exc=1, badaddr=addr and data=0.
- **ACCESS** (exactly 1 cycle):
  - `o_mem_addr` = latched addr.
  - For a store: `o_mem_outsize` = size and `o_mem_insize` = 0.
  - For a load: `o_mem_insize` = size, `o_mem_outsize` = 0 and `o_mem_insign` = sign.
  - At the closing edge, the RAM commits any store, the unit captures `i_mem_data` (load) or 0 (store) into the response register, and the FSM moves to RESP.
- **RESP:** `o_rsp_valid`=1 and the response fields are held stable until `i_rsp_ready`.
  - On handshake with a simultaneous new accepted request, go to ACCESS (or RESP again on exception).
  - Otherwise go to IDLE.
- **Outside ACCESS:** `o_mem_insize`=`o_mem_outsize`=0 and `o_mem_insign`=0. `o_mem_addr` and `o_mem_data` hold their latched values.
- **Check** (fails when any holds):
  - size not in {1,2,4};
  - size==2 and addr[0]=1;
  - size==4 and addr[1:0]!=0;
  - addr+size > `MEM_BYTES`, computed in 33 bits so wrap-around at 0xFFFFFFFF counts as out of range.
- Stores always produce a response, so every request yields exactly one response in request order.

## Timing
- **Reset values:** state IDLE, so `o_req_ready`=1. All other outputs are 0.
- **Load/store latency:** accept at edge N puts ACCESS in cycle N..N+1, and `o_rsp_valid` rises after edge N+1.
- **Exception latency:** `o_rsp_valid` rises after edge N; no RAM cycle is issued.
- **Throughput:** back-to-back requests sustain one request per 2 cycles when `i_rsp_ready` is held high.
- **Reset mid-operation:** asserting `i_rst_n` low forces `o_mem_outsize`=0 immediately, asynchronously. A store whose ACCESS cycle is interrupted before its edge is not written. A pending response is discarded.
- **Backpressure:** a held response never changes, and `o_req_ready` stays 0 while `i_rsp_ready`=0.

## Configuration
- `LSU_ADDR_CHECK_EN` defined: the full check above is active.
- `LSU_ADDR_CHECK_EN` undefined:
  - no check is performed, and every request goes through ACCESS;
  - `o_rsp_exc` and `o_rsp_badaddr` are tied to 0;
  - the size is still forced to 0 on the RAM ports when it is not in {1,2,4}, so invalid sizes neither read nor write.

## Structure
- **Shared `defs.v`:** holds `` `MEM_SIZE ``, the size encodings `` `SZ_BYTE ``=1, `` `SZ_HALF ``=2 and `` `SZ_WORD ``=4, and the FSM state encodings `` `LSU_IDLE ``, `` `LSU_ACCESS `` and `` `LSU_RESP ``.
- **Sub-module `lsu_check`:** combinational; inputs addr and size; output fault. It is instantiated only under `LSU_ADDR_CHECK_EN`.

## Test plan
- **Reset:** hold `i_rst_n`=0 -> `o_req_ready`=1 and all other outputs 0. Release -> no RAM write observed.
- **Word round trip:** store word 0xDEADBEEF to addr 0x10, then load word 0x10 -> rsp_data=0xDEADBEEF. The store response has data 0 and matching rd.
- **Signed and unsigned byte load:** store byte 0x80 at 0x21. Signed byte load -> 0xFFFFFF80. Unsigned -> 0x00000080. Signed half-load at 0x20 -> sign-extended {mem[0x20],0x80}.
- **Misalignment:** word load at 0x12, with macro on -> exc=1, badaddr=0x12, response after 1 edge, RAM outsize/insize stay 0. With macro off -> a RAM access occurs.
- **Range:** word store at `MEM_BYTES`-2 and at 0xFFFFFFFE -> both exc=1, memory unchanged.
- **Backpressure and reset:** hold `i_rsp_ready`=0 for 5 cycles -> response stable and `o_req_ready`=0. Then a store with reset asserted during ACCESS -> target bytes unchanged.
